// File: rtl/scmp_bus_target.sv
// SC/MP external-bus responder: latches the address on ADS, then services one read or write
// from an internal byte RAM with programmable wait states. Define SCMP_TGT_ERR_EN for bus_err.
module scmp_bus_target #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_ADS_n,
  input  logic        bus_RD_n,
  input  logic        bus_WR_n,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  output logic [7:0]  bus_dout,
  output logic        bus_dout_oe,
  output logic        bus_hold_n
`ifdef SCMP_TGT_ERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  typedef enum logic [2:0] {
    IDLE, ADDR, RD_WAIT, RD_DATA, WR_WAIT, WR_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_d;
  logic              oe_d, hold_d, err_d, mem_we;
  logic [7:0]        mem [DEPTH];

  // Upper address bits are deliberately not decoded (RAM aliases over the 64K space).
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_addr;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = bus_dout;
    oe_d    = bus_dout_oe;
    hold_d  = bus_hold_n;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus_ADS_n) begin
          addr_d  = bus_addr[ADDR_W-1:0];
          state_d = ADDR;
        end
        if (!bus_RD_n || !bus_WR_n) err_d = 1'b1;
      end
      ADDR: begin
        if (!bus_ADS_n) begin
          addr_d = bus_addr[ADDR_W-1:0];
        end else if (!bus_RD_n && bus_WR_n) begin
          cnt_d = WAIT_CNT;
          if (WAIT_STATES == 0) begin
            dout_d  = mem[addr_q];
            oe_d    = 1'b1;
            state_d = RD_DATA;
          end else begin
            hold_d  = 1'b0;
            state_d = RD_WAIT;
          end
        end else if (bus_RD_n && !bus_WR_n) begin
          cnt_d = WAIT_CNT;
          if (WAIT_STATES == 0) begin
            mem_we  = 1'b1;
            state_d = WR_DONE;
          end else begin
            hold_d  = 1'b0;
            state_d = WR_WAIT;
          end
        end
        if (!bus_RD_n && !bus_WR_n) err_d = 1'b1;
      end
      RD_WAIT: begin
        // Completes at the W-th edge after the strobe was first sampled, strobe or not.
        if (cnt_q <= CNT_W'(1)) begin
          dout_d  = mem[addr_q];
          oe_d    = 1'b1;
          hold_d  = 1'b1;
          state_d = RD_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (!bus_ADS_n) err_d = 1'b1;
      end
      RD_DATA: begin
        if (bus_RD_n) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          mem_we  = 1'b1;
          hold_d  = 1'b1;
          state_d = WR_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (!bus_ADS_n) err_d = 1'b1;
      end
      WR_DONE: begin
        if (bus_WR_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      bus_dout    <= '0;
      bus_dout_oe <= 1'b0;
      bus_hold_n  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      bus_dout    <= dout_d;
      bus_dout_oe <= oe_d;
      bus_hold_n  <= hold_d;
    end
  end

`ifdef SCMP_TGT_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) bus_err <= 1'b0;
    else        bus_err <= err_d;
  end
`else
  logic unused_err;
  assign unused_err = err_d;
`endif

  // RAM contents survive reset; a write pending at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[addr_q] <= bus_din;
  end

endmodule

// File: tb/tb_scmp_bus_target.sv
// Bench for scmp_bus_target: two instances (0 and 3 wait states) on shared strobes,
// checked against an array memory model and an arithmetic access timeline.
module tb_scmp_bus_target;

  localparam int unsigned AW = 12;
  localparam int unsigned W0 = 0;
  localparam int unsigned W1 = 3;

  logic        clk = 1'b0;
  logic        rst_n, ads_n, rd_n, wr_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout_w [2];
  logic        oe_w   [2];
  logic        hold_w [2];
`ifdef SCMP_TGT_ERR_EN
  logic        err_w  [2];
`endif

  int          ws [2];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mem_m [4096];
  logic [7:0]  dout_exp;
  logic [AW-1:0] written [$];

  always #5 clk = ~clk;

  scmp_bus_target #(.ADDR_W(AW), .WAIT_STATES(W0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus_ADS_n(ads_n), .bus_RD_n(rd_n), .bus_WR_n(wr_n),
    .bus_addr(addr), .bus_din(din), .bus_dout(dout_w[0]), .bus_dout_oe(oe_w[0]),
    .bus_hold_n(hold_w[0])
`ifdef SCMP_TGT_ERR_EN
    , .bus_err(err_w[0])
`endif
  );

  scmp_bus_target #(.ADDR_W(AW), .WAIT_STATES(W1)) u3 (
    .clk(clk), .rst_n(rst_n), .bus_ADS_n(ads_n), .bus_RD_n(rd_n), .bus_WR_n(wr_n),
    .bus_addr(addr), .bus_din(din), .bus_dout(dout_w[1]), .bus_dout_oe(oe_w[1]),
    .bus_hold_n(hold_w[1])
`ifdef SCMP_TGT_ERR_EN
    , .bus_err(err_w[1])
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp);
`ifdef SCMP_TGT_ERR_EN
    for (int i = 0; i < 2; i++) chk(tag, i, 8'(err_w[i]), 8'(exp));
`else
    if (exp) chk(tag, 0, 8'(exp), 8'(exp === 1'b1));
`endif
  endtask

  task automatic chk_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_hold"}, i, 8'(hold_w[i]), 8'd1);
      chk({tag, "_oe"},   i, 8'(oe_w[i]),   8'd0);
      chk({tag, "_dout"}, i, dout_w[i],     dout_exp);
    end
  endtask

  // One ADS then a read or write strobe held low for l sampling edges.
  task automatic access(input bit is_rd, input logic [15:0] a, input logic [7:0] d, input int l);
    logic [7:0] old_v, new_v;
    int kmax;
    ads_n = 1'b0; addr = a;
    step();
    chk_quiet("ads");
    chk_err("ads_err", 1'b0);
    ads_n = 1'b1; addr = 16'($urandom);
    if (is_rd) rd_n = 1'b0;
    else begin wr_n = 1'b0; din = d; end
    old_v = dout_exp;
    new_v = is_rd ? mem_m[a[AW-1:0]] : old_v;
    kmax  = (l > 4) ? l : 4;
    for (int k = 0; k <= kmax; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        int w;
        int done;
        w    = ws[i];
        done = (l > w + 1) ? l : w + 1;
        chk(is_rd ? "rd_hold" : "wr_hold", i, 8'(hold_w[i]), (k < w) ? 8'd0 : 8'd1);
        chk(is_rd ? "rd_oe" : "wr_oe", i, 8'(oe_w[i]),
            (is_rd && k >= w && k < done) ? 8'd1 : 8'd0);
        chk(is_rd ? "rd_dout" : "wr_dout", i, dout_w[i], (is_rd && k >= w) ? new_v : old_v);
      end
      chk_err("acc_err", 1'b0);
      if (k + 1 >= l) begin rd_n = 1'b1; wr_n = 1'b1; end
      if (k >= 3) din = 8'($urandom);
    end
    if (is_rd) dout_exp = new_v;
    else begin
      mem_m[a[AW-1:0]] = d;
      written.push_back(a[AW-1:0]);
    end
  endtask

  initial begin
    ws[0] = int'(W0);
    ws[1] = int'(W1);
    rst_n = 1'b0; ads_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = '0; din = '0;
    dout_exp = 8'h00;
    step();
    step();
    chk_quiet("reset");
    chk_err("reset_err", 1'b0);
    rst_n = 1'b1;
    step();

    // Basic write then read, zero-wait timing and wait-state timing side by side.
    access(1'b0, 16'h0123, 8'h5A, 1);
    access(1'b1, 16'h0123, 8'h00, 3);
    access(1'b0, 16'h0040, 8'hC3, 4);
    access(1'b1, 16'h0040, 8'h00, 5);

    // Aliasing of undecoded upper address bits.
    access(1'b0, 16'hF010, 8'h77, 2);
    access(1'b1, 16'h0010, 8'h00, 4);

    // Reset in the middle of a waited read.
    access(1'b0, 16'h0200, 8'h9E, 2);
    ads_n = 1'b0; addr = 16'h0040;
    step();
    ads_n = 1'b1; rd_n = 1'b0;
    step();
    step();
    chk("mid_hold", 1, 8'(hold_w[1]), 8'd0);
    rst_n = 1'b0;
    step();
    dout_exp = 8'h00;
    chk_quiet("mid_rst");
    rst_n = 1'b1; rd_n = 1'b1;
    step();
    chk_quiet("post_rst");
    access(1'b1, 16'h0200, 8'h00, 4);
    access(1'b1, 16'h0040, 8'h00, 1);

    // Strobes without ADS, and both strobes together in ADDR, are ignored.
    rd_n = 1'b0;
    step();
    chk_quiet("noads");
    chk_err("noads_err", 1'b1);
    rd_n = 1'b1;
    step();
    chk_err("noads_err_clr", 1'b0);
    ads_n = 1'b0; addr = 16'h0123;
    step();
    ads_n = 1'b1; rd_n = 1'b0; wr_n = 1'b0; din = 8'hEE;
    step();
    chk_quiet("both");
    chk_err("both_err", 1'b1);
    rd_n = 1'b1; wr_n = 1'b1;
    step();
    chk_err("both_err_clr", 1'b0);
    access(1'b1, 16'h0123, 8'h00, 2);

    // Second ADS re-latches the address before the read.
    access(1'b0, 16'h0001, 8'h11, 1);
    access(1'b0, 16'h0002, 8'h22, 1);
    ads_n = 1'b0; addr = 16'h0001;
    step();
    access(1'b1, 16'h0002, 8'h00, 2);

    // Random mix of reads and writes with random strobe lengths and alias bits.
    for (int n = 0; n < 60; n++) begin
      bit          is_rd;
      logic [15:0] a;
      int          l;
      is_rd = (written.size() > 0) && ($urandom_range(1) == 1);
      l     = int'($urandom_range(6, 1));
      if (is_rd) a = {4'($urandom), written[$urandom_range(written.size() - 1)]};
      else       a = 16'($urandom);
      access(is_rd, a, 8'($urandom), l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
